// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix feeder/multiplier pair: FSM states, beat geometry
// and beat-packing slot order.
package matrix_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } feeder_state_t;

    localparam int MW_DEFAULT   = 4;
    localparam int SLOTS        = 4;
    localparam int ISSUE_CYCLES = 4;

    // Element order inside a beat, most significant element first.
    localparam int SLOT_A0 = 0;
    localparam int SLOT_A1 = 1;
    localparam int SLOT_B0 = 2;
    localparam int SLOT_B1 = 3;

    function automatic int beats_for(input int mw);
        return mw * mw / 2;
    endfunction

    localparam int BEATS = beats_for(MW_DEFAULT);

endpackage

// File: rtl/matrix_stream_feeder_addr_gen.sv
// Column/row-pair/slot counters of the feeder and the registered element address
// they select (base + r*MW + c, wrapping modulo 2^ADDR_WIDTH).
module feeder_addr_gen
    import matrix_pkg::*;
#(
    parameter int MATRIX_WIDTH = 4,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_a_base,
    input  logic [ADDR_WIDTH-1:0] i_b_base,
    input  logic                  i_step,
    input  logic                  i_next,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [1:0]            o_slot,
    output logic                  o_last_slot,
    output logic                  o_last_beat
);

    localparam int CW = $clog2(MATRIX_WIDTH);
    localparam logic [CW-1:0] ROW_LAST = CW'(MATRIX_WIDTH - 2);
    localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_WIDTH - 1);

    logic [ADDR_WIDTH-1:0] r_a_base;
    logic [ADDR_WIDTH-1:0] r_b_base;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [1:0]            r_slot;
    logic [CW-1:0]         w_next_row;
    logic [CW-1:0]         w_next_col;
    logic [1:0]            w_next_slot;

    function automatic logic [ADDR_WIDTH-1:0] elem_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [CW-1:0]         row,
        input logic [CW-1:0]         col
    );
        return base + ADDR_WIDTH'(row) * ADDR_WIDTH'(MATRIX_WIDTH) + ADDR_WIDTH'(col);
    endfunction

    assign w_next_slot = r_slot + 2'd1;
    assign w_next_row  = (r_row == ROW_LAST) ? '0 : r_row + CW'(2);
    assign w_next_col  = (r_row == ROW_LAST) ? r_col + CW'(1) : r_col;

    // Slot bit 1 selects the B matrix, slot bit 0 the odd row of the pair.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a_base <= '0;
            r_b_base <= '0;
            r_addr   <= '0;
            r_row    <= '0;
            r_col    <= '0;
            r_slot   <= '0;
        end else if (i_load) begin
            r_a_base <= i_a_base;
            r_b_base <= i_b_base;
            r_row    <= '0;
            r_col    <= '0;
            r_slot   <= '0;
            r_addr   <= elem_addr(i_a_base, '0, '0);
        end else if (i_step) begin
            r_slot <= w_next_slot;
            r_addr <= elem_addr(w_next_slot[1] ? r_b_base : r_a_base,
                                r_row + CW'(w_next_slot[0]), r_col);
        end else if (i_next) begin
            r_row  <= w_next_row;
            r_col  <= w_next_col;
            r_slot <= '0;
            r_addr <= elem_addr(r_a_base, w_next_row, w_next_col);
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_slot      = r_slot;
    assign o_last_slot = (r_slot == 2'(ISSUE_CYCLES - 1));
    assign o_last_beat = (r_row == ROW_LAST) && (r_col == COL_LAST);

endmodule

// File: rtl/matrix_stream_feeder.sv
// Streams A/B column pairs from a single-port element memory into 4-element beats.
// Optional MATRIX_FEEDER_STALL_EN adds a hold input that stretches EMIT.
module matrix_stream_feeder
    import matrix_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NUM_ELEMENTS = 4,
    parameter int MATRIX_WIDTH = 4,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_WIDTH-1:0]         a_base,
    input  logic [ADDR_WIDTH-1:0]         b_base,
`ifdef MATRIX_FEEDER_STALL_EN
    input  logic                          hold,
`endif
    output logic                          busy,
    output logic                          done,
    output logic                          mem_ren,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    input  logic [WIDTH-1:0]              mem_rdata,
    output logic                          read_en,
    output logic [NUM_ELEMENTS*WIDTH-1:0] rdata
);

    localparam int SLOT_W = $clog2(SLOTS);

    feeder_state_t                 r_state;
    logic                          r_busy;
    logic                          r_done;
    logic                          r_mem_ren;
    logic                          r_read_en;
    logic [NUM_ELEMENTS*WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0]              r_gath_a0;
    logic [WIDTH-1:0]              r_gath_a1;
    logic [WIDTH-1:0]              r_gath_b0;
    logic                          r_cap_vld;
    logic [SLOT_W-1:0]             r_cap_slot;

    logic                          w_hold;
    logic                          w_load;
    logic                          w_step;
    logic                          w_next;
    logic [1:0]                    w_slot;
    logic                          w_last_slot;
    logic                          w_last_beat;

`ifdef MATRIX_FEEDER_STALL_EN
    assign w_hold  = hold;
    assign read_en = r_read_en & ~hold;
`else
    assign w_hold  = 1'b0;
    assign read_en = r_read_en;
`endif

    assign w_load = (r_state == ST_IDLE)  && start;
    assign w_step = (r_state == ST_ISSUE) && !w_last_slot;
    assign w_next = (r_state == ST_EMIT)  && !w_hold && !w_last_beat;

    feeder_addr_gen #(
        .MATRIX_WIDTH (MATRIX_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_a_base    (a_base),
        .i_b_base    (b_base),
        .i_step      (w_step),
        .i_next      (w_next),
        .o_mem_addr  (mem_addr),
        .o_slot      (w_slot),
        .o_last_slot (w_last_slot),
        .o_last_beat (w_last_beat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mem_ren <= 1'b0;
            r_read_en <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state   <= ST_ISSUE;
                        r_busy    <= 1'b1;
                        r_mem_ren <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (w_last_slot) begin
                        r_state   <= ST_WAIT;
                        r_mem_ren <= 1'b0;
                    end
                end
                // The last slot's data is on mem_rdata now, so it bypasses the gather stage.
                ST_WAIT: begin
                    r_state   <= ST_EMIT;
                    r_read_en <= 1'b1;
                    r_rdata   <= {r_gath_a0, r_gath_a1, r_gath_b0, mem_rdata};
                end
                ST_EMIT: begin
                    if (!w_hold) begin
                        r_read_en <= 1'b0;
                        if (w_last_beat) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state   <= ST_ISSUE;
                            r_mem_ren <= 1'b1;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap_vld  <= 1'b0;
            r_cap_slot <= '0;
            r_gath_a0  <= '0;
            r_gath_a1  <= '0;
            r_gath_b0  <= '0;
        end else begin
            r_cap_vld  <= r_mem_ren;
            r_cap_slot <= SLOT_W'(w_slot);
            if (r_cap_vld) begin
                case (r_cap_slot)
                    SLOT_W'(SLOT_A0): r_gath_a0 <= mem_rdata;
                    SLOT_W'(SLOT_A1): r_gath_a1 <= mem_rdata;
                    SLOT_W'(SLOT_B0): r_gath_b0 <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign mem_ren = r_mem_ren;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_matrix_stream_feeder.sv
// Directed bench for matrix_stream_feeder with a synchronous element-memory model.
module tb_matrix_stream_feeder;
    import matrix_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a_base = 8'h00;
    logic [7:0]  b_base = 8'h00;
`ifdef MATRIX_FEEDER_STALL_EN
    logic        hold = 1'b0;
`endif
    logic        busy;
    logic        done;
    logic        mem_ren;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        read_en;
    logic [31:0] rdata;

    logic [7:0]  mem [0:255];
    logic [31:0] obs_beats [0:7];
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_addr];

    matrix_stream_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_base    (a_base),
        .b_base    (b_base),
`ifdef MATRIX_FEEDER_STALL_EN
        .hold      (hold),
`endif
        .busy      (busy),
        .done      (done),
        .mem_ren   (mem_ren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .read_en   (read_en),
        .rdata     (rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_beat(input logic [7:0] ab, input logic [7:0] bb, input int k);
        logic [7:0] r, c, a0, a1, b0, b1;
        c  = 8'(k / 2);
        r  = 8'((k % 2) * 2);
        a0 = ab + r * 8'd4 + c;
        a1 = ab + (r + 8'd1) * 8'd4 + c;
        b0 = bb + r * 8'd4 + c;
        b1 = bb + (r + 8'd1) * 8'd4 + c;
        return {mem[a0], mem[a1], mem[b0], mem[b1]};
    endfunction

    // Caller is positioned at a negedge; start is sampled at the next posedge (E0).
    task automatic run_pair(input logic [7:0] ab, input logic [7:0] bb, input int p1, input int p2);
        int beat;
        logic exp_re;
        logic [7:0] exp_addr;
        beat   = 0;
        a_base = ab;
        b_base = bb;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 49; cyc++) begin
            if (cyc > 1) @(negedge clk);
            exp_re = (cyc % 6 == 0) && (cyc <= 48);
            check("read_en", 32'(read_en), 32'(exp_re));
            check("busy", 32'(busy), 32'(cyc <= 48));
            check("done", 32'(done), 32'(cyc == 49));
            check("mem_ren", 32'(mem_ren), 32'((cyc % 6 >= 1) && (cyc % 6 <= 4) && (cyc <= 48)));
            if (cyc <= 4) begin
                exp_addr = (cyc == 1) ? ab : (cyc == 2) ? ab + 8'd4 : (cyc == 3) ? bb : bb + 8'd4;
                check("mem_addr", 32'(mem_addr), 32'(exp_addr));
            end
            if (exp_re && beat < 8) begin
                check("rdata", rdata, model_beat(ab, bb, beat));
                obs_beats[beat] = rdata;
                beat++;
            end
            start = (cyc == p1) || (cyc == p2);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mem[r * 4 + c]        = 8'(r * 4 + c + 1);
                mem[8'h40 + r * 4 + c] = 8'(8'h80 + r * 4 + c);
            end

        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_ren", 32'(mem_ren), 32'd0);
        check("rst_read_en", 32'(read_en), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Basic run with hand-computed beats.
        @(negedge clk);
        run_pair(8'h00, 8'h40, 0, 0);
        check("s1_beat0", obs_beats[0], 32'h01058084);
        check("s1_beat1", obs_beats[1], 32'h090D888C);
        check("s1_beat7", obs_beats[7], 32'h0C108B8F);

        // Back-to-back start in the cycle after done; stray starts mid-run ignored.
        @(negedge clk);
        run_pair(8'h00, 8'h40, 3, 20);
        check("b2b_beat0", obs_beats[0], 32'h01058084);

        // Start during DONE is ignored.
        @(negedge clk);
        run_pair(8'h00, 8'h40, 49, 0);
        @(negedge clk);
        start = 1'b0;
        check("done_start_busy", 32'(busy), 32'd0);
        check("done_start_ren", 32'(mem_ren), 32'd0);
        @(negedge clk);
        check("done_start_busy2", 32'(busy), 32'd0);
        check("done_start_ren2", 32'(mem_ren), 32'd0);
        check("rdata_hold", rdata, 32'h0C108B8F);

        // Address wrap-around of A.
        @(negedge clk);
        run_pair(8'hF8, 8'h40, 0, 0);
        check("wrap_beat0", obs_beats[0], 32'hF8FC8084);
        check("wrap_beat1", obs_beats[1], 32'h0105888C);

        // Asynchronous reset mid-run.
        @(negedge clk);
        a_base = 8'h00;
        b_base = 8'h40;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_mem_ren", 32'(mem_ren), 32'd0);
        check("mrst_read_en", 32'(read_en), 32'd0);
        check("mrst_mem_addr", 32'(mem_addr), 32'd0);
        check("mrst_rdata", rdata, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("mrst_no_done", 32'(done), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("mrst_idle", 32'(busy), 32'd0);
        @(negedge clk);
        run_pair(8'h00, 8'h40, 0, 0);
        check("mrst_beat0", obs_beats[0], 32'h01058084);

`ifdef MATRIX_FEEDER_STALL_EN
        // hold during cycles 6-9 stretches the first EMIT to cycle 10.
        @(negedge clk);
        a_base = 8'h00;
        b_base = 8'h40;
        start  = 1'b1;
        for (int cyc = 1; cyc <= 53; cyc++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            hold  = (cyc >= 6) && (cyc <= 9);
            @(negedge clk);
            check("stall_read_en", 32'(read_en), 32'((cyc >= 10) && ((cyc - 10) % 6 == 0) && (cyc <= 52)));
            check("stall_busy", 32'(busy), 32'(cyc <= 52));
            check("stall_done", 32'(done), 32'(cyc == 53));
            if (cyc >= 6 && cyc <= 10) check("stall_rdata", rdata, 32'h01058084);
            if (cyc == 52) check("stall_last", rdata, 32'h0C108B8F);
        end
        hold = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
